// File: rtl/deser_pkg.sv
// Shared types and constants for the deserializer with output word FIFO.
//   asm_state_t : assembler state machine encoding
//   LSB_FIRST_C / MSB_FIRST_C : values for the MSB_FIRST bit-order parameter
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFTING,
        BLOCKED
    } asm_state_t;

    localparam bit LSB_FIRST_C = 1'b0;
    localparam bit MSB_FIRST_C = 1'b1;

endpackage

// File: rtl/deser_fifo.sv
// Synchronous first-word-fall-through FIFO for assembled words.
// Ports:
//   clock_100KHz : clock, rising edge
//   reset        : asynchronous active-high reset (empties the FIFO)
//   push         : write push_data at the tail (ignored when full)
//   push_data    : word to write
//   pop          : advance the head (ignored when empty)
//   head         : word at the head, 0 when empty
//   count        : number of stored words, 0..DEPTH
//   full, empty  : occupancy flags decoded from count
module deser_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clock_100KHz,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    // Gate the head so a stale entry never shows while empty.
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clock_100KHz) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel converter that assembles DATA_WIDTH-bit words and queues
// them in a DEPTH-entry FWFT FIFO.
// Ports:
//   clock_100KHz : clock, rising edge
//   reset        : asynchronous active-high reset
//   data_in      : serial data bit
//   write_in     : data_in valid this cycle
//   status_out   : a bit offered this cycle will be accepted
//   data_out     : FIFO head word (0 when empty)
//   data_ready   : FIFO non-empty
//   ack_in       : pop the head word
//   count_out    : number of buffered words
//   drop_out     : one-cycle pulse after a bit was offered with status_out low
module deserializador_fifo
    import deser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          MSB_FIRST  = LSB_FIRST_C
) (
    input  logic                         clock_100KHz,
    input  logic                         reset,
    input  logic                         data_in,
    input  logic                         write_in,
    output logic                         status_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_ready,
    input  logic                         ack_in,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         drop_out
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH-1);

    asm_state_t            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]      pos;
    logic                  drop_q;
    logic                  accept, push, pop;
    logic                  fifo_full, fifo_empty;

    // Registered-only decode: no path from write_in or ack_in.
    assign status_out = !((bit_cnt_q == LAST) && fifo_full);
    assign accept     = write_in && status_out;
    assign pop        = ack_in && !fifo_empty;
    assign data_ready = !fifo_empty;
    assign drop_out   = drop_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        pos       = (MSB_FIRST == MSB_FIRST_C) ? (LAST - bit_cnt_q) : bit_cnt_q;
        word      = shift_q;
        word[pos] = data_in;

        unique case (state_q)
            IDLE, SHIFTING: begin
                if (accept) begin
                    if (bit_cnt_q == LAST) begin
                        // Completed word leaves on this edge, including the new bit.
                        push      = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = word;
                        // The FIFO only fills from our own pushes, so full can
                        // only coincide with the last slot right here.
                        if ((bit_cnt_d == LAST) && fifo_full && !pop) begin
                            state_d = BLOCKED;
                        end else begin
                            state_d = SHIFTING;
                        end
                    end
                end
            end
            BLOCKED: begin
                if (pop) state_d = SHIFTING;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            drop_q    <= write_in && !status_out;
        end
    end

    deser_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .push         (push),
        .push_data    (word),
        .pop          (pop),
        .head         (data_out),
        .count        (count_out),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

endmodule
